pipeline_stall_ctrl: RTL

//  Consumer of hazard-detection requests for the 16-bit 5-stage pipeline. Turns Stall,

---
 rtl/pipeline_stall_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/pipeline_stall_ctrl.sv
// Purpose: turns hazard-unit stall, ID redirect and halt requests into pipeline enables,
//          and sequences the halt drain. It also keeps saturating perf counters and a stall watchdog.
// Latency: enables are combinational (same edge); state and counters update one edge later. No backpressure.
module pipeline_stall_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int MAX_STALL    = 8,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Stall_Req,
    input  logic             Branch_Taken,
    input  logic             Jump_Taken,
    input  logic             Halt_Req,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Bubble,
    output logic             Halted,
    output logic             Stall_Timeout,
    output logic [CNT_W-1:0] Stall_Count,
    output logic [CNT_W-1:0] Flush_Count,
    output logic [CNT_W-1:0] Cycle_Count
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYCLES - 1);
    localparam logic [7:0] STALL_TRIP = 8'(MAX_STALL);

    state_t     state;
    logic [2:0] drain_cnt;
    logic [7:0] run_cnt;

    logic in_run;
    logic halt_go;
    logic stall_go;
    logic redirect_go;

    // Stall wins over halt and redirect: a stalled instruction has not really been decoded yet.
    always_comb begin
        in_run      = (state == ST_RUN);
        stall_go    = in_run & Stall_Req;
        halt_go     = in_run & Halt_Req & ~Stall_Req;
        redirect_go = in_run & ~Stall_Req & ~Halt_Req & (Branch_Taken | Jump_Taken);
    end

    always_comb begin
        PC_Write     = in_run & ~Stall_Req & ~Halt_Req;
        IF_ID_Write  = in_run & ~Stall_Req & ~Halt_Req;
        IF_ID_Flush  = ~in_run | redirect_go;
        ID_EX_Bubble = ~in_run | stall_go;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_RUN;
            drain_cnt     <= '0;
            run_cnt       <= '0;
            Halted        <= 1'b0;
            Stall_Timeout <= 1'b0;
            Stall_Count   <= '0;
            Flush_Count   <= '0;
            Cycle_Count   <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (halt_go) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= DRAIN_INIT;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == 3'd0) begin
                        state  <= ST_HALTED;
                        Halted <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - 3'd1;
                    end
                end
                ST_HALTED: begin
                    Halted <= 1'b1;
                end
                default: begin
                    state  <= ST_HALTED;
                    Halted <= 1'b1;
                end
            endcase

            // The watchdog only observes stalls; it never changes how a stall is applied.
            if (stall_go) begin
                if (run_cnt != 8'hFF)
                    run_cnt <= run_cnt + 8'd1;
                if (run_cnt + 8'd1 >= STALL_TRIP && run_cnt != 8'hFF)
                    Stall_Timeout <= 1'b1;
                if (Stall_Count != '1)
                    Stall_Count <= Stall_Count + CNT_W'(1);
            end else begin
                run_cnt <= '0;
            end

            if (redirect_go && Flush_Count != '1)
                Flush_Count <= Flush_Count + CNT_W'(1);

            if (state != ST_HALTED && Cycle_Count != '1)
                Cycle_Count <= Cycle_Count + CNT_W'(1);
        end
    end

endmodule
